// File: rtl/button_event_ctrl_pkg.sv
// Shared constants, register decode and event bit layout for the button event controller.
package button_event_ctrl_pkg;

   // Register offsets, decoded from addr[3:2]
   localparam logic [1:0] EV_DATA  = 2'd0;
   localparam logic [1:0] EV_EVENT = 2'd1;
   localparam logic [1:0] EV_IRQEN = 2'd2;
   localparam logic [1:0] EV_HOLD  = 2'd3;

   // Event bit positions inside EVENT / IRQ_EN
   localparam int unsigned EVB_PRESS = 0;
   localparam int unsigned EVB_LONG  = 4;
   localparam int unsigned EVB_SWCHG = 8;

   localparam int unsigned EV_W = 9;
   localparam logic [EV_W-1:0] EV_MASK = 9'h1FF;

   typedef enum logic [1:0] {
      RegData  = EV_DATA,
      RegEvent = EV_EVENT,
      RegIrqEn = EV_IRQEN,
      RegHold  = EV_HOLD
   } ev_reg_e;

   // Word select from a byte address; the two low address bits are ignored.
   function automatic ev_reg_e decode_reg(input logic [3:0] addr);
      return ev_reg_e'(addr[3:2]);
   endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Single-cycle register bus between the core and the button event controller.
interface button_event_ctrl_if;

   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output we,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  we,
      input  addr,
      input  wdata,
      output rdata
   );

endinterface

// File: rtl/button_hold_counter.sv
// Long-press detector for one button: counts held cycles and emits one pulse per hold.
module button_hold_counter #(
   parameter int unsigned HOLD_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn,
   input  logic [HOLD_W-1:0] threshold,
   output logic              long_pulse
);

   logic [HOLD_W-1:0] count_q, count_d;
   logic              lp_done_q, lp_done_d;

   // Pulse once the count has reached the threshold; a lowered threshold fires on the next cycle.
   always_comb begin
      long_pulse = ~lp_done_q && (count_q != '0) && (count_q >= threshold);
      count_d    = count_q;
      lp_done_d  = lp_done_q;
      if (!btn) begin
         // Release rearms the detector, even in the cycle the pulse fires.
         count_d   = '0;
         lp_done_d = 1'b0;
      end else begin
         if (count_q < threshold) begin
            count_d = count_q + HOLD_W'(1);
         end
         if (long_pulse) begin
            lp_done_d = 1'b1;
         end
      end
   end

   // Counter and one-shot flag state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         lp_done_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         lp_done_q <= lp_done_d;
      end
   end

endmodule

// File: rtl/button_event_ctrl.sv
// Button/switch event controller: edge and long-press detection, sticky W1C events, masked IRQ.
module button_event_ctrl
   import button_event_ctrl_pkg::*;
#(
   parameter int unsigned       N_BTN        = 4,
   parameter int unsigned       N_SW         = 16,
   parameter int unsigned       HOLD_W       = 24,
   parameter logic [HOLD_W-1:0] HOLD_DEFAULT = HOLD_W'(5_000_000)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         sw_bt,
   button_event_ctrl_if.slave  bus,
   output logic                irq
);

   localparam int unsigned InW = N_SW + N_BTN;

   logic [InW-1:0]    prev_q;
   logic              primed_q;
   logic [EV_W-1:0]   event_q, event_d;
   logic [EV_W-1:0]   irq_en_q, irq_en_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              irq_q, irq_d;

   logic [EV_W-1:0]   new_ev;
   logic [EV_W-1:0]   clr_mask;
   logic [N_BTN-1:0]  btn;
   logic [N_BTN-1:0]  press;
   logic [N_BTN-1:0]  long_pulse;
   ev_reg_e           sel;

   logic unused_bits;
   assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:HOLD_W], sw_bt[31:InW]};

   assign sel = decode_reg(bus.addr);
   assign btn = sw_bt[N_SW +: N_BTN];

   for (genvar i = 0; i < N_BTN; i++) begin : g_hold
      button_hold_counter #(
         .HOLD_W (HOLD_W)
      ) u_hold (
         .clk        (clk),
         .rst        (rst),
         .btn        (btn[i]),
         .threshold  (hold_q),
         .long_pulse (long_pulse[i])
      );
   end

   // New events this cycle; nothing is reported until prev has been loaded once.
   always_comb begin
      new_ev = '0;
      press  = btn & ~prev_q[N_SW +: N_BTN];
      if (primed_q) begin
         new_ev[EVB_PRESS +: N_BTN] = press;
         new_ev[EVB_LONG +: N_BTN]  = long_pulse;
         new_ev[EVB_SWCHG]          = |(sw_bt[N_SW-1:0] ^ prev_q[N_SW-1:0]);
      end
   end

   // Bus write decode and next register values; a new event beats its own W1C clear.
   always_comb begin
      clr_mask = '0;
      irq_en_d = irq_en_q;
      hold_d   = hold_q;
      if (bus.we) begin
         unique case (sel)
            RegEvent: clr_mask = bus.wdata[EV_W-1:0] & EV_MASK;
            RegIrqEn: irq_en_d = bus.wdata[EV_W-1:0] & EV_MASK;
            RegHold: begin
               // A zero threshold would never be reached by a counter that starts at 1.
               if (bus.wdata[HOLD_W-1:0] == '0) begin
                  hold_d = HOLD_W'(1);
               end else begin
                  hold_d = bus.wdata[HOLD_W-1:0];
               end
            end
            default: ;  // DATA is read-only
         endcase
      end
      event_d = (event_q & ~clr_mask) | new_ev;
      irq_d   = |(event_d & irq_en_d);
   end

   // Registered state: input history, event/config registers and the interrupt flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
         event_q  <= '0;
         irq_en_q <= '0;
         hold_q   <= HOLD_DEFAULT;
         irq_q    <= 1'b0;
      end else begin
         prev_q   <= sw_bt[InW-1:0];
         primed_q <= 1'b1;
         event_q  <= event_d;
         irq_en_q <= irq_en_d;
         hold_q   <= hold_d;
         irq_q    <= irq_d;
      end
   end

   // Zero-latency read mux; reading EVENT has no side effect.
   always_comb begin
      bus.rdata = '0;
      unique case (sel)
         RegData:  bus.rdata[InW-1:0]    = sw_bt[InW-1:0];
         RegEvent: bus.rdata[EV_W-1:0]   = event_q;
         RegIrqEn: bus.rdata[EV_W-1:0]   = irq_en_q;
         RegHold:  bus.rdata[HOLD_W-1:0] = hold_q;
         default:  bus.rdata = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Randomised and directed bench for button_event_ctrl against a cycle-level behavioural model.
module tb_button_event_ctrl;

   localparam logic [31:0] HoldDefault = 32'd5_000_000;

   logic        clk;
   logic        rst;
   logic [31:0] sw_bt;
   logic        irq;

   button_event_ctrl_if bus ();

   button_event_ctrl #(
      .N_BTN        (4),
      .N_SW         (16),
      .HOLD_W       (24),
      .HOLD_DEFAULT (24'd5_000_000)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw_bt (sw_bt),
      .bus   (bus),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Model state: what software should see, from the rules for presses, holds and W1C.
   logic [31:0] m_prev;
   bit          m_primed;
   logic [8:0]  m_ev;
   logic [8:0]  m_en;
   int unsigned m_hold;
   bit          m_irq;
   int unsigned m_held [4];   // consecutive sampled-high cycles per button
   bit          m_fired [4];  // long press already reported for the current hold

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev   = '0;
      m_primed = 1'b0;
      m_ev     = '0;
      m_en     = '0;
      m_hold   = HoldDefault;
      m_irq    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_held[i]  = 0;
         m_fired[i] = 1'b0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [8:0] nev;
      logic [8:0] clr;
      nev = '0;
      if (m_primed) begin
         for (int i = 0; i < 4; i++) nev[i] = sw_bt[16+i] & ~m_prev[16+i];
         nev[8] = (sw_bt[15:0] != m_prev[15:0]);
      end
      for (int i = 0; i < 4; i++) begin
         if (!m_fired[i] && m_held[i] > 0 && m_held[i] >= m_hold) nev[4+i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         if (!sw_bt[16+i]) begin
            m_held[i]  = 0;
            m_fired[i] = 1'b0;
         end else begin
            if (nev[4+i]) m_fired[i] = 1'b1;
            if (m_held[i] < 32'h7fff_ffff) m_held[i]++;
         end
      end
      clr = (bus.we && bus.addr[3:2] == 2'd1) ? bus.wdata[8:0] : 9'h0;
      m_ev = (m_ev & ~clr) | nev;
      if (bus.we && bus.addr[3:2] == 2'd2) m_en = bus.wdata[8:0];
      if (bus.we && bus.addr[3:2] == 2'd3) begin
         m_hold = (bus.wdata[23:0] == 24'd0) ? 1 : int'(bus.wdata[23:0]);
      end
      m_irq    = |(m_ev & m_en);
      m_prev   = sw_bt;
      m_primed = 1'b1;
   endtask

   function automatic logic [31:0] m_rdata(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return {12'h0, sw_bt[19:0]};
         2'd1:    return {23'h0, m_ev};
         2'd2:    return {23'h0, m_en};
         default: return {8'h0, m_hold[23:0]};
      endcase
   endfunction

   // One clock: drive inputs, step the model, sample on the falling edge.
   task automatic cycle(input logic [31:0] sw, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input string tag);
      sw_bt     = sw;
      bus.we    = we;
      bus.addr  = a;
      bus.wdata = wd;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "/irq"}, 32'(irq), 32'(m_irq));
      check_eq({tag, "/rdata"}, bus.rdata, m_rdata(bus.addr));
   endtask

   // Combinational read between edges.
   task automatic peek(input logic [3:0] a, input string tag);
      bus.we   = 1'b0;
      bus.addr = a;
      #1;
      check_eq(tag, bus.rdata, m_rdata(a));
   endtask

   // Asynchronous reset asserted mid-cycle, released on the next falling edge.
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_eq({tag, "/irq"}, 32'(irq), 32'h0);
      peek(4'h4, {tag, "/event"});
      peek(4'hC, {tag, "/hold"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_random(input int unsigned n);
      logic [31:0] sw;
      logic [3:0]  a;
      logic [31:0] wd;
      int unsigned op;
      int unsigned k;
      sw = sw_bt;
      cycle(sw, 1'b1, 4'hC, 32'($urandom_range(0, 12)), "rnd_hold");
      cycle(sw, 1'b1, 4'h8, $urandom, "rnd_en");
      for (int n_i = 0; n_i < int'(n); n_i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset("rnd_rst");
            cycle(sw, 1'b1, 4'hC, 32'($urandom_range(0, 12)), "rnd_hold");
         end
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 7) == 0) sw[16+b] = ~sw[16+b];
         end
         if ($urandom_range(0, 15) == 0) begin
            k = $urandom_range(0, 15);
            sw[k] = ~sw[k];
         end
         if ($urandom_range(0, 31) == 0) sw[31:20] = 12'($urandom);
         op = $urandom_range(0, 7);
         a  = 4'($urandom);
         wd = $urandom;
         if (op == 0 && a[3:2] == 2'd3) wd = 32'($urandom_range(0, 12));
         cycle(sw, op < 2, a, wd, "rnd");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, limit 2000000 ns reached");
      $fatal(1);
   end

   initial begin
      int first_i;
      int rises;
      logic last_b;

      // Reset with buttons held: first edge only primes, no events.
      rst       = 1'b1;
      sw_bt     = 32'h000F_0000;
      bus.we    = 1'b0;
      bus.addr  = 4'h0;
      bus.wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cycle(32'h000F_0000, 1'b0, 4'h0, 32'h0, "t1");
      check_eq("t1_data", bus.rdata, 32'h000F_0000);
      peek(4'h4, "t1_event");
      check_eq("t1_event_zero", bus.rdata, 32'h0);
      cycle(32'h0, 1'b0, 4'h4, 32'h0, "t1_rel");

      // Press with IRQ enabled, then W1C.
      cycle(32'h0, 1'b1, 4'h8, 32'h1, "t2_en");
      cycle(32'h0001_0000, 1'b0, 4'h4, 32'h0, "t2_press");
      check_eq("t2_ev0", bus.rdata, 32'h1);
      check_eq("t2_irq", 32'(irq), 32'h1);
      cycle(32'h0001_0000, 1'b1, 4'h4, 32'h1, "t2_w1c");
      check_eq("t2_ev_clr", bus.rdata, 32'h0);
      check_eq("t2_irq_clr", 32'(irq), 32'h0);
      cycle(32'h0, 1'b0, 4'h4, 32'h0, "t2_rel");

      // Long press with threshold 10, held 30 cycles.
      cycle(32'h0, 1'b1, 4'hC, 32'd10, "t3_cfg");
      first_i = -1;
      rises   = 0;
      last_b  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle(32'h0002_0000, i == 15, 4'h4, 32'h20, "t3_hold");
         if (bus.rdata[5] && first_i < 0) first_i = i;
         if (bus.rdata[5] && !last_b) rises++;
         last_b = bus.rdata[5];
      end
      check_eq("t3_first", 32'(first_i), 32'd10);
      check_eq("t3_once", 32'(rises), 32'd1);
      cycle(32'h0, 1'b1, 4'h4, 32'h1FF, "t3_rel");
      for (int i = 0; i < 10; i++) cycle(32'h0002_0000, 1'b0, 4'h4, 32'h0, "t3_hold2");
      cycle(32'h0, 1'b0, 4'h4, 32'h0, "t3_rel2");
      check_eq("t3_refire", 32'(bus.rdata[5]), 32'h1);

      // Press in the same cycle as its W1C clear.
      cycle(32'h0, 1'b1, 4'h4, 32'h1FF, "t4_clr");
      cycle(32'h0004_0000, 1'b1, 4'h4, 32'h4, "t4_race");
      check_eq("t4_set_wins", 32'(bus.rdata[2]), 32'h1);
      cycle(32'h0, 1'b0, 4'h4, 32'h0, "t4_rel");

      // Switch change, DATA read-only, IRQ_EN read mask.
      cycle(32'h0, 1'b1, 4'h4, 32'h1FF, "t5_clr");
      cycle(32'h8, 1'b0, 4'h4, 32'h0, "t5_sw");
      check_eq("t5_swchg", 32'(bus.rdata[8]), 32'h1);
      cycle(32'h8, 1'b1, 4'h4, 32'h100, "t5_w1c");
      check_eq("t5_swchg_clr", bus.rdata, 32'h0);
      cycle(32'h8, 1'b1, 4'h0, 32'hDEAD_BEEF, "t5_data_wr");
      check_eq("t5_data", bus.rdata, 32'h8);
      cycle(32'h8, 1'b1, 4'h8, 32'hFFFF_FFFF, "t5_en_wr");
      check_eq("t5_en_mask", bus.rdata, 32'h0000_01FF);
      cycle(32'h8, 1'b1, 4'hC, 32'h0, "t5_hold0");
      check_eq("t5_hold_min", bus.rdata, 32'h1);

      // Reset in the middle of a hold.
      cycle(32'h8, 1'b1, 4'hC, 32'd10, "t6_cfg");
      for (int i = 0; i < 5; i++) cycle(32'h0001_0008, 1'b0, 4'h4, 32'h0, "t6_hold");
      do_reset("t6_rst");
      check_eq("t6_hold_default", bus.rdata, HoldDefault);
      cycle(32'h0001_0008, 1'b0, 4'h4, 32'h0, "t6_post");
      check_eq("t6_no_event", bus.rdata, 32'h0);

      run_random(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
